mips_harvard_bus_bridge: RTL
============================

Name: mips_harvard_bus_bridge

Overview:
- Lets a Harvard-style MIPS core (separate instruction and data ports) run on a single shared memory bus that can stall via waitrequest.
- Arbitrates between fetch and load/store, registers one bus transaction at a time, returns read data with a one-cycle valid pulse, and aborts hung transactions with a timeout.
- Sits between the core top level and the external memory/bus model; the core stalls on each port until that port's valid pulse.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; must be a multiple of 8.
- DATA_PRIORITY, 1, 1 = data port wins simultaneous requests; 0 = strict alternation (round-robin, last-granted loses).
- TIMEOUT, 255, max consecutive waitrequest cycles before abort; 0 disables the timeout.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- instr_req  input  1  fetch request, level, held until instr_valid
- instr_address  input  ADDR_W  fetch address
- instr_readdata  output  DATA_W  fetched word, registered
- instr_valid  output  1  one-cycle pulse: instr_readdata valid
- data_read  input  1  load request, level, held until data_valid
- data_write  input  1  store request, level, held until data_valid
- data_address  input  ADDR_W  load/store address
- data_writedata  input  DATA_W  store data
- data_byteenable  input  DATA_W/8  store/load byte lanes
- data_readdata  output  DATA_W  load result, registered
- data_valid  output  1  one-cycle pulse: data transaction complete
- bus_err  output  1  one-cycle pulse, coincident with valid, on timeout abort
- bus_address  output  ADDR_W  registered bus address
- bus_read  output  1  registered bus read strobe
- bus_write  output  1  registered bus write strobe
- bus_writedata  output  DATA_W  registered bus write data
- bus_byteenable  output  DATA_W/8  registered bus byte lanes (all ones for fetch)
- bus_waitrequest  input  1  bus stall; transfer completes in a cycle with strobe=1 and waitrequest=0
- bus_readdata  input  DATA_W  valid in the completing cycle

Behaviour:
- States: IDLE, BUS, RESP.
- Reset: state IDLE; all outputs 0 (readdata regs, valids, bus_err, bus strobes, address, writedata, byteenable); timeout counter 0; round-robin pointer set to favour data.
- Reset takes effect at the next edge from any state; a bus strobe drops at that edge; any pending response is discarded, with no valid pulse.
- IDLE, no request: stay in IDLE.
- IDLE, request present: pick the winner by DATA_PRIORITY or round-robin; latch address, data and byteenable onto bus_*; assert bus_read or bus_write; go to BUS.
- data_read and data_write both high: treated as a write.
- BUS, waitrequest=0: capture bus_readdata into the winner's readdata register (reads only); drop the strobe; go to RESP.
- BUS, waitrequest=1: bus_* held stable and the counter increments.
- Timeout: when the counter reaches TIMEOUT (and TIMEOUT!=0), drop the strobe; go to RESP with error flag set; readdata register set to 0.
- RESP: pulse the winner's valid for exactly one cycle, plus bus_err if the error flag is set; clear the counter; update the round-robin pointer; go to IDLE.
- RESP: requests are not sampled. The core updates its request at the edge that ends the valid cycle.
- Minimum latency: request in IDLE at cycle N, strobe in N+1, valid in N+2 with zero wait states. Each wait state adds one cycle; waitrequest in cycle N+1 gives valid in N+3.
- instr_valid and data_valid are never high together; at most one bus strobe is high at any time.
- A request that drops while not granted is simply not serviced.
- The readdata registers keep their value until the next completion on that port.
- The counter is at least clog2(TIMEOUT+1) bits wide and never wraps.

Test Plan:
- Fetch, no wait: instr_req=1, instr_address=0xBFC00000, bus_readdata=0x24020005, waitrequest=0 → bus_read high cycle 1 with bus_address=0xBFC00000 and byteenable=0xF; instr_valid cycle 2 with instr_readdata=0x24020005.
- Store with 3 wait states: data_write=1, addr=0x1000, wdata=0xDEADBEEF, be=0x3 → bus_write held 4 cycles with stable outputs; data_valid on cycle 5; no instr_valid.
- Contention: instr_req and data_read both high with DATA_PRIORITY=1 → data served first, then the fetch. With DATA_PRIORITY=0 and repeated contention → grants alternate D, I, D, I.
- Timeout: TIMEOUT=4, waitrequest stuck at 1 on a load → strobe drops after 4 wait cycles; data_valid and bus_err pulse together; data_readdata=0; the next fetch then completes normally.
- Reset mid-transaction: reset during BUS with waitrequest=1 → at the next edge strobes are 0, state IDLE, no valid pulse; a new fetch after reset returns correct data.
- Read/write conflict: data_read=1 and data_write=1 → a single bus_write issued, bus_read stays 0.

Source files
------------

// File: rtl/mips_harvard_bus_bridge.sv
// Bridges a Harvard MIPS core's fetch and load/store ports onto one shared,
// stallable memory bus: one registered transaction at a time, with timeout abort.
module mips_harvard_bus_bridge #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int DATA_PRIORITY = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_req,
  input  logic [ADDR_W-1:0]   instr_address,
  output logic [DATA_W-1:0]   instr_readdata,
  output logic                instr_valid,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_address,
  input  logic [DATA_W-1:0]   data_writedata,
  input  logic [DATA_W/8-1:0] data_byteenable,
  output logic [DATA_W-1:0]   data_readdata,
  output logic                data_valid,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   bus_address,
  output logic                bus_read,
  output logic                bus_write,
  output logic [DATA_W-1:0]   bus_writedata,
  output logic [DATA_W/8-1:0] bus_byteenable,
  input  logic                bus_waitrequest,
  input  logic [DATA_W-1:0]   bus_readdata,
  output logic [1:0]          dbg_state_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Debug encoding: 0 = IDLE, 1 = BUS, 2 = RESP.
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t           state_q;
  logic             grant_data_q;
  logic             favor_data_q;
  logic [CNT_W-1:0] cnt_q;

  logic data_req;
  logic pick_data;
  logic timeout_hit;

  // Handshake: each core port holds its request level until its one-cycle valid;
  // a bus transfer completes in a cycle with a strobe high and waitrequest low.
  assign data_req    = data_read | data_write;
  assign pick_data   = data_req & (~instr_req | (DATA_PRIORITY != 0) | favor_data_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_data_q   <= 1'b0;
      favor_data_q   <= 1'b1;
      cnt_q          <= '0;
      instr_readdata <= '0;
      instr_valid    <= 1'b0;
      data_readdata  <= '0;
      data_valid     <= 1'b0;
      bus_err        <= 1'b0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= '0;
      bus_byteenable <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_req || data_req) begin
            grant_data_q   <= pick_data;
            bus_address    <= pick_data ? data_address : instr_address;
            bus_writedata  <= pick_data ? data_writedata : '0;
            bus_byteenable <= pick_data ? data_byteenable : '1;
            // A simultaneous read and write request is serviced as a write.
            bus_write      <= pick_data & data_write;
            bus_read       <= ~(pick_data & data_write);
            cnt_q          <= '0;
            state_q        <= BUS;
          end
        end
        BUS: begin
          if (!bus_waitrequest) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            if (bus_read) begin
              if (grant_data_q) data_readdata  <= bus_readdata;
              else              instr_readdata <= bus_readdata;
            end
            instr_valid <= ~grant_data_q;
            data_valid  <= grant_data_q;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            if (grant_data_q) data_readdata  <= '0;
            else              instr_readdata <= '0;
            instr_valid <= ~grant_data_q;
            data_valid  <= grant_data_q;
            bus_err     <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          instr_valid  <= 1'b0;
          data_valid   <= 1'b0;
          bus_err      <= 1'b0;
          cnt_q        <= '0;
          favor_data_q <= ~grant_data_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
